// File: rtl/div_unit.sv
// Multicycle restoring shift-subtract divider for DIV/DIVU.
// Produces one quotient bit per cycle. Quotient goes to lo_out and remainder to hi_out. A zero divisor is flagged and not computed.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   acc_shift;
    logic [WIDTH:0]   trial;

    // abs(most-negative) wraps to itself, which is the correct unsigned magnitude
    assign a_mag = (is_signed && a_in[WIDTH-1]) ? (~a_in + ONE) : a_in;
    assign b_mag = (is_signed && b_in[WIDTH-1]) ? (~b_in + ONE) : b_in;

    // The dividend register shifts its MSB into the partial remainder.
    // Quotient bits fill the dividend register from the bottom.
    assign acc_shift = {acc_q, quo_q[WIDTH-1]};
    assign trial     = acc_shift - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (b_in == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        acc_d   = '0;
                        count_d = '0;
                        q_neg_d = is_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                        r_neg_d = is_signed & a_in[WIDTH-1];
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = acc_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = q_neg_q ? (~quo_q + ONE) : quo_q;
                hi_d    = r_neg_q ? (~acc_q + ONE) : acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            acc_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. Expected results are queued when a start is driven.
// They are popped and compared when done is seen.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_signed(is_signed),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on the language's own division operators
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000;
                e.hi = 32'h0;
            end else begin
                e.lo = sa / sb;
                e.hi = sa % sb;
            end
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    // Called at a negedge. Pulses start for one cycle and scrambles the operands afterwards.
    // Returns at the negedge where done is first seen, so a caller may start again in the done cycle.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int inject_cyc,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output int lat, output int bcnt, output bit timed_out);
        is_signed = s;
        a_in      = a;
        b_in      = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        a_in      = $urandom;
        b_in      = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        lat       = 0;
        bcnt      = 0;
        timed_out = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat       = c;
                timed_out = 1'b0;
                break;
            end
            start = (c == inject_cyc);
            @(negedge clk);
        end
        start = 1'b0;
        lo    = lo_out;
        hi    = hi_out;
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        a_in      = 32'h1234_5678;
        b_in      = 32'h0000_0003;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'b0) begin
            bad++;
            $display("FAIL reset_hold: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'b0) begin
            bad++;
            $display("FAIL reset_release: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        last_exp = '0;
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_directed;
        logic        vs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] va[6]  = '{32'd7, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100};
        logic [31:0] vb[6]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'h10, 32'h10, 32'd100};
        logic [31:0] vlo[6] = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h0FFF_FFFF, 32'h0, 32'd1};
        logic [31:0] vhi[6] = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'hF, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          bcnt;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(exp_t'{lo: vlo[i], hi: vhi[i]});
            run_div(vs[i], va[i], vb[i], -1, lo, hi, lat, bcnt, to);
            e = sb_q.pop_front();
            last_exp = e;
            total++;
            if (to || {lo, hi} !== {e.lo, e.hi}) begin
                bad++;
                $display("FAIL directed_%0d result: got lo=%h hi=%h timeout=%0d want lo=%h hi=%h",
                         i, lo, hi, to, e.lo, e.hi);
            end
            total++;
            if (lat != 33 || bcnt != 33) begin
                bad++;
                $display("FAIL directed_%0d timing: got latency=%0d busy_cycles=%0d want 33/33", i, lat, bcnt);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL directed_%0d done_pulse: got done=%b busy=%b want 0/0", i, done, busy);
            end
            $display("directed %0d: s=%0d a=%h b=%h -> lo=%h hi=%h lat=%0d", i, vs[i], va[i], vb[i], lo, hi, lat);
        end
    endtask

    task automatic test_div_zero;
        is_signed = 1'b1;
        a_in      = 32'd5;
        b_in      = 32'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({div_zero, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL div_zero_pulse: got dz=%b busy=%b done=%b want 1/0/0", div_zero, busy, done);
        end
        total++;
        if ({lo_out, hi_out} !== {last_exp.lo, last_exp.hi}) begin
            bad++;
            $display("FAIL div_zero_hold: got lo=%h hi=%h want lo=%h hi=%h", lo_out, hi_out, last_exp.lo, last_exp.hi);
        end
        @(negedge clk);
        total++;
        if ({div_zero, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL div_zero_end: got dz=%b busy=%b done=%b want 0/0/0", div_zero, busy, done);
        end
        $display("div_zero: a=5 b=0 flagged for one cycle");
    endtask

    task automatic test_overflow_ignore;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          bcnt;
        bit          to;
        exp_t        e;
        sb_q.push_back(exp_t'{lo: 32'h8000_0000, hi: 32'h0});
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 15, lo, hi, lat, bcnt, to);
        e = sb_q.pop_front();
        last_exp = e;
        total++;
        if (to || {lo, hi} !== {e.lo, e.hi}) begin
            bad++;
            $display("FAIL overflow result: got lo=%h hi=%h timeout=%0d want lo=%h hi=%h", lo, hi, to, e.lo, e.hi);
        end
        total++;
        if (lat != 33 || bcnt != 33) begin
            bad++;
            $display("FAIL overflow timing: got latency=%0d busy_cycles=%0d want 33/33", lat, bcnt);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start: got busy=%b done=%b want 0/0", busy, done);
        end
        $display("overflow: 80000000/ffffffff -> lo=%h hi=%h with start injected mid-CALC", lo, hi);
    endtask

    task automatic test_async_reset;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          bcnt;
        bit          to;
        exp_t        e;
        is_signed = 1'b0;
        a_in      = 32'h1234_5678;
        b_in      = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL async_pre_busy: got busy=%b want 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({busy, done, div_zero, hi_out, lo_out} !== 67'b0) begin
            bad++;
            $display("FAIL async_clear: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     busy, done, div_zero, hi_out, lo_out);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, hi_out, lo_out} !== 66'b0) begin
            bad++;
            $display("FAIL async_after_release: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi_out, lo_out);
        end
        sb_q.push_back(exp_t'{lo: 32'd14, hi: 32'd2});
        run_div(1'b0, 32'd100, 32'd7, -1, lo, hi, lat, bcnt, to);
        e = sb_q.pop_front();
        last_exp = e;
        total++;
        if (to || {lo, hi} !== {e.lo, e.hi} || lat != 33) begin
            bad++;
            $display("FAIL async_recover: got lo=%h hi=%h latency=%0d want lo=%h hi=%h latency=33",
                     lo, hi, lat, e.lo, e.hi);
        end
        @(negedge clk);
        $display("async_reset: cleared mid-division, DIVU 100/7 -> lo=%0d hi=%0d", lo, hi);
    endtask

    task automatic test_back_to_back;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        int          bcnt;
        bit          to;
        exp_t        e;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b = (i % 4 == 0) ? 32'hFFFF_FFFF : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (b == 32'h0) b = 32'd1;
            sb_q.push_back(model(s, a, b));
            run_div(s, a, b, -1, lo, hi, lat, bcnt, to);
            e = sb_q.pop_front();
            last_exp = e;
            total++;
            if (to || {lo, hi} !== {e.lo, e.hi} || lat != 33) begin
                bad++;
                $display("FAIL b2b_%0d: got lo=%h hi=%h latency=%0d want lo=%h hi=%h latency=33",
                         i, lo, hi, lat, e.lo, e.hi);
            end
            $display("b2b %0d: s=%0d a=%h b=%h -> lo=%h hi=%h lat=%0d", i, s, a, b, lo, hi, lat);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_overflow_ignore();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
